// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/branch/halt sequencing FSM for the instruction_memory_pc path
//
// Purpose: decodes each fetched instruction and drives the PC update controls.
// Ordinary instructions are offered downstream over a valid/ready handshake.
// BR/BZ are resolved here by redirecting the PC. HALT stops fetching until reset.
//
// Ports:
//   CLK, reset        clock, asynchronous active-high reset
//   start             leave IDLE (ignored elsewhere)
//   instr             current instruction, opcode = instr[23:20], offset = instr[7:0]
//   zero_flag         zero result of last executed instruction
//   flag_valid        zero_flag covers every issued instruction
//   issue_ready       execute stage accepts this cycle
//   PCEn, PCSrc       PC write enable, 1 = PC + immediate / 0 = PC + 1
//   immediate         branch offset to PC adder (0 unless PCSrc)
//   issue_valid       issue_instr is offered downstream
//   issue_instr       offered instruction
//   halted            registered, high in HALT
//   issue_count       registered, saturating count of accepted instructions
//   branch_count      registered, saturating count of taken branches
module fetch_sequencer #(
    parameter logic [3:0] HALT_OP = 4'h7,
    parameter logic [3:0] BR_OP   = 4'h5,
    parameter logic [3:0] BZ_OP   = 4'h6,
    parameter int         CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [23:0]      instr,
    input  logic             zero_flag,
    input  logic             flag_valid,
    input  logic             issue_ready,
    output logic             PCEn,
    output logic             PCSrc,
    output logic [7:0]       immediate,
    output logic             issue_valid,
    output logic [23:0]      issue_instr,
    output logic             halted,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] branch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;

    logic [3:0] opcode;
    logic       transfer;
    logic       taken;
    logic       halt_seen;

    assign opcode = instr[23:20];

    // Mealy decode: everything here is zero outside RUN so IDLE/HALT and an
    // asynchronous reset silence the PC controls immediately.
    always_comb begin
        PCEn        = 1'b0;
        PCSrc       = 1'b0;
        immediate   = 8'h00;
        issue_valid = 1'b0;
        issue_instr = 24'h000000;
        transfer    = 1'b0;
        taken       = 1'b0;
        halt_seen   = 1'b0;
        if (state == RUN) begin
            issue_instr = instr;
            if (opcode == HALT_OP) begin
                halt_seen = 1'b1;
            end else if (opcode == BR_OP) begin
                taken = 1'b1;
            end else if (opcode == BZ_OP) begin
                if (flag_valid) begin
                    if (zero_flag) begin
                        taken = 1'b1;
                    end else begin
                        PCEn = 1'b1;
                    end
                end
            end else begin
                issue_valid = 1'b1;
                transfer    = issue_ready;
                PCEn        = issue_ready;
            end
            if (taken) begin
                PCEn      = 1'b1;
                PCSrc     = 1'b1;
                immediate = instr[7:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            halted       <= 1'b0;
            issue_count  <= '0;
            branch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (halt_seen) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                    if (transfer && (issue_count != {CNT_W{1'b1}})) begin
                        issue_count <= issue_count + 1'b1;
                    end
                    if (taken && (branch_count != {CNT_W{1'b1}})) begin
                        branch_count <= branch_count + 1'b1;
                    end
                end
                HALT: begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] instr;
    logic        zero_flag;
    logic        flag_valid;
    logic        issue_ready;

    logic        PCEn, PCSrc, issue_valid, halted;
    logic [7:0]  immediate;
    logic [23:0] issue_instr;
    logic [15:0] issue_count, branch_count;

    logic        PCEn4, PCSrc4, issue_valid4, halted4;
    logic [7:0]  immediate4;
    logic [23:0] issue_instr4;
    logic [3:0]  issue_count4, branch_count4;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_sequencer dut (
        .CLK(CLK), .reset(reset), .start(start), .instr(instr),
        .zero_flag(zero_flag), .flag_valid(flag_valid), .issue_ready(issue_ready),
        .PCEn(PCEn), .PCSrc(PCSrc), .immediate(immediate),
        .issue_valid(issue_valid), .issue_instr(issue_instr), .halted(halted),
        .issue_count(issue_count), .branch_count(branch_count)
    );

    fetch_sequencer #(.CNT_W(4)) dut4 (
        .CLK(CLK), .reset(reset), .start(start), .instr(instr),
        .zero_flag(zero_flag), .flag_valid(flag_valid), .issue_ready(issue_ready),
        .PCEn(PCEn4), .PCSrc(PCSrc4), .immediate(immediate4),
        .issue_valid(issue_valid4), .issue_instr(issue_instr4), .halted(halted4),
        .issue_count(issue_count4), .branch_count(branch_count4)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        st;
        logic [23:0] ins;
        logic        zf;
        logic        fv;
        logic        rdy;
        logic        e_pcen;
        logic        e_pcsrc;
        logic [7:0]  e_imm;
        logic        e_valid;
        logic        e_halted;
        logic [15:0] e_icnt;
        logic [15:0] e_bcnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic st, input logic [23:0] ins,
                       input logic zf, input logic fv, input logic rdy,
                       input logic pcen, input logic pcsrc, input logic [7:0] imm,
                       input logic vld, input logic hlt,
                       input logic [15:0] icnt, input logic [15:0] bcnt);
        vec_t v;
        v.rst = rst; v.st = st; v.ins = ins; v.zf = zf; v.fv = fv; v.rdy = rdy;
        v.e_pcen = pcen; v.e_pcsrc = pcsrc; v.e_imm = imm; v.e_valid = vld;
        v.e_halted = hlt; v.e_icnt = icnt; v.e_bcnt = bcnt;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; instr = 24'h0;
        zero_flag = 1'b0; flag_valid = 1'b0; issue_ready = 1'b0;

        //   rst st  instr      zf fv rdy  pcen src imm   vld hlt icnt bcnt
        add(1, 0, 24'h100001, 0, 0, 1,   0, 0, 8'h00, 0, 0, 0, 0); // reset state
        add(0, 1, 24'h100001, 0, 0, 1,   0, 0, 8'h00, 0, 0, 0, 0); // IDLE + start
        add(0, 0, 24'h100001, 0, 0, 1,   1, 0, 8'h00, 1, 0, 0, 0); // transfer 1
        add(0, 0, 24'h200002, 0, 0, 1,   1, 0, 8'h00, 1, 0, 1, 0); // transfer 2
        add(0, 0, 24'h700007, 0, 0, 1,   0, 0, 8'h00, 0, 0, 2, 0); // halt decode
        add(0, 1, 24'h100001, 0, 0, 1,   0, 0, 8'h00, 0, 1, 2, 0); // HALT, start ignored
        add(0, 1, 24'h100001, 0, 0, 1,   0, 0, 8'h00, 0, 1, 2, 0); // still HALT
        add(1, 0, 24'h100001, 0, 0, 1,   0, 0, 8'h00, 0, 0, 0, 0); // reset out of HALT
        add(0, 1, 24'h100001, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0); // start again
        add(0, 0, 24'h100001, 0, 0, 0,   0, 0, 8'h00, 1, 0, 0, 0); // stall 1
        add(0, 0, 24'h100001, 0, 0, 0,   0, 0, 8'h00, 1, 0, 0, 0); // stall 2
        add(0, 0, 24'h100001, 0, 0, 0,   0, 0, 8'h00, 1, 0, 0, 0); // stall 3
        add(0, 0, 24'h100001, 0, 0, 1,   1, 0, 8'h00, 1, 0, 0, 0); // single transfer
        add(0, 0, 24'h5000FC, 0, 0, 0,   1, 1, 8'hFC, 0, 0, 1, 0); // BR, ready ignored
        add(0, 0, 24'h600004, 1, 0, 1,   0, 0, 8'h00, 0, 0, 1, 1); // BZ stall, zf ignored
        add(0, 0, 24'h600004, 1, 0, 1,   0, 0, 8'h00, 0, 0, 1, 1); // BZ stall
        add(0, 0, 24'h600004, 1, 1, 1,   1, 1, 8'h04, 0, 0, 1, 1); // BZ taken
        add(0, 0, 24'h600004, 0, 0, 1,   0, 0, 8'h00, 0, 0, 1, 2); // BZ stall
        add(0, 0, 24'h600004, 0, 1, 1,   1, 0, 8'h00, 0, 0, 1, 2); // BZ not taken
        add(0, 0, 24'h100001, 0, 0, 0,   0, 0, 8'h00, 1, 0, 1, 2); // stall before reset
        add(1, 0, 24'h100001, 0, 0, 0,   0, 0, 8'h00, 0, 0, 0, 0); // reset mid stall
        add(1, 0, 24'h100001, 0, 0, 1,   0, 0, 8'h00, 0, 0, 0, 0); // held in reset

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst; start = vecs[i].st; instr = vecs[i].ins;
            zero_flag = vecs[i].zf; flag_valid = vecs[i].fv; issue_ready = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d PCEn", i), {31'b0, PCEn}, {31'b0, vecs[i].e_pcen});
            chk($sformatf("v%0d PCSrc", i), {31'b0, PCSrc}, {31'b0, vecs[i].e_pcsrc});
            chk($sformatf("v%0d immediate", i), {24'b0, immediate}, {24'b0, vecs[i].e_imm});
            chk($sformatf("v%0d issue_valid", i), {31'b0, issue_valid}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid)
                chk($sformatf("v%0d issue_instr", i), {8'b0, issue_instr}, {8'b0, vecs[i].ins});
            chk($sformatf("v%0d halted", i), {31'b0, halted}, {31'b0, vecs[i].e_halted});
            chk($sformatf("v%0d issue_count", i), {16'b0, issue_count}, {16'b0, vecs[i].e_icnt});
            chk($sformatf("v%0d branch_count", i), {16'b0, branch_count}, {16'b0, vecs[i].e_bcnt});
            chk($sformatf("v%0d w4 PCEn", i), {31'b0, PCEn4}, {31'b0, vecs[i].e_pcen});
            chk($sformatf("v%0d w4 halted", i), {31'b0, halted4}, {31'b0, vecs[i].e_halted});
            @(posedge CLK); #1;
        end

        // Saturation: 20 back-to-back transfers, 4-bit counter must stick at 4'hF.
        reset = 1'b0; start = 1'b1; instr = 24'h100001; issue_ready = 1'b1;
        flag_valid = 1'b0; zero_flag = 1'b0;
        @(posedge CLK); #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk($sformatf("sat%0d count4", i), {28'b0, issue_count4},
                (i > 15) ? 32'd15 : i);
            chk($sformatf("sat%0d issue_valid4", i), {31'b0, issue_valid4}, 32'd1);
            instr = (i[0]) ? 24'h100001 : 24'h200002;
            @(posedge CLK); #1;
        end
        chk("sat final count4", {28'b0, issue_count4}, 32'd15);
        chk("sat final count16", {16'b0, issue_count}, 32'd20);

        // Saturated branch counter on the narrow instance: 17 taken BRs.
        for (int i = 0; i < 17; i++) begin
            instr = 24'h500003;
            @(posedge CLK); #1;
        end
        chk("sat branch4", {28'b0, branch_count4}, 32'd15);
        chk("sat branch16", {16'b0, branch_count}, 32'd17);

        // Halt afterwards and confirm PCEn stays low with start pulses.
        instr = 24'h700000;
        @(posedge CLK); #1;
        instr = 24'h100001; start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("halt%0d halted", i), {31'b0, halted}, 32'd1);
            chk($sformatf("halt%0d PCEn", i), {31'b0, PCEn}, 32'd0);
            chk($sformatf("halt%0d issue_valid", i), {31'b0, issue_valid}, 32'd0);
            @(posedge CLK); #1;
        end
        chk("halt issue_count held", {16'b0, issue_count}, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
